bank_erase_ctrl: RTL and testbench



---
 rtl/bank_erase_pkg.sv | 22 ++
 rtl/bank_erase_ctrl_if.sv | 39 +++
 rtl/erase_w_gen.sv | 37 +++
 rtl/bank_erase_ctrl.sv | 152 +++++++++++++++
 tb/tb_bank_erase_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_erase_pkg.sv
// Shared constants, FSM state type and helpers for the bank erase controller.
package bank_erase_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } erase_state_e;

  // AWSIZE encoding: log2 of the bytes per beat of a DATA_WBITS-wide bus.
  function automatic logic [2:0] axi_size(input int data_wbits);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == (data_wbits / 8)) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/bank_erase_ctrl_if.sv
// AXI4 write-only bus between the erase controller (master) and the bank's
// memory port (slave).
//
// Handshake: every channel transfers on a cycle where VALID and READY are both
// high at the rising clock edge. A master holds VALID and its payload stable
// until that transfer; READY may toggle freely.
interface bank_erase_ctrl_if #(
  parameter int DATA_WBITS = 512,
  parameter int ADDR_BITS  = 64
);
  logic [ADDR_BITS-1:0]    M_AXI_AWADDR;
  logic [7:0]              M_AXI_AWLEN;
  logic [2:0]              M_AXI_AWSIZE;
  logic [1:0]              M_AXI_AWBURST;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WBITS-1:0]   M_AXI_WDATA;
  logic [DATA_WBITS/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WLAST;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_BREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_BREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );
endinterface

// File: rtl/erase_w_gen.sv
// Write-data channel of the erase controller: streams beats of whole bursts
// whenever an issued (or issuing) AW burst still lacks its data.
module erase_w_gen #(
  parameter int BURST_BEATS = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic bursts_avail,
  input  logic wready,
  output logic wvalid,
  output logic wlast,
  output logic burst_done
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_BEATS - 1);

  logic [7:0] beat_q;
  logic       at_last;
  logic       w_hs;

  assign at_last    = (beat_q == LAST_BEAT);
  assign wvalid     = run & bursts_avail;
  assign wlast      = wvalid & at_last;
  assign w_hs       = wvalid & wready;
  assign burst_done = w_hs & at_last;

  // Beat position inside the current burst; wraps after the last beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_q <= 8'd0;
    end else if (w_hs) begin
      beat_q <= at_last ? 8'd0 : beat_q + 8'd1;
    end
  end

endmodule

// File: rtl/bank_erase_ctrl.sv
// AXI4 write master that fills one DDR bank with FILL_PATTERN on request.
// Optional feature macro: BANK_ERASE_TIMER_EN (measures erase duration into
// erase_cycles; without it erase_cycles is constant 0).
module bank_erase_ctrl
  import bank_erase_pkg::*;
#(
  parameter int                   DATA_WBITS      = 512,
  parameter int                   ADDR_BITS       = 64,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR       = '0,
  parameter logic [63:0]          RAM_BYTES       = 64'h4_0000_0000,
  parameter int                   BURST_BEATS     = 64,
  parameter int                   MAX_OUTSTANDING = 16,
  parameter logic [31:0]          FILL_PATTERN    = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                erase_ram,
  output logic                erase_idle,
  output logic                erase_error,
  output logic [31:0]         erase_cycles,
  output erase_state_e        dbg_state,
  bank_erase_ctrl_if.master   m_axi
);

  localparam int                   DB          = DATA_WBITS / 8;
  localparam logic [63:0]          BURST_B64   = 64'(BURST_BEATS * DB);
  localparam logic [63:0]          NBURSTS_64  = RAM_BYTES / BURST_B64;
  localparam logic [31:0]          NBURSTS     = NBURSTS_64[31:0];
  localparam logic [ADDR_BITS-1:0] BURST_BYTES = ADDR_BITS'(BURST_BEATS * DB);
  localparam int                   OUT_W       = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]     OUT_MAX     = OUT_W'(MAX_OUTSTANDING);

  erase_state_e         state_q, state_d;
  logic                 erase_start, erase_done, run;
  logic [31:0]          aw_cnt, w_cnt, b_cnt;
  logic [OUT_W-1:0]     outstanding_q;
  logic [ADDR_BITS-1:0] awaddr_q;
  logic                 erase_error_q;
  logic                 awvalid, aw_hs, b_hs, bursts_avail, burst_done;

  assign run          = (state_q == RUN);
  assign awvalid      = run && (aw_cnt < NBURSTS) && (outstanding_q < OUT_MAX);
  assign aw_hs        = awvalid & m_axi.M_AXI_AWREADY;
  assign b_hs         = run & m_axi.M_AXI_BVALID;
  // A burst whose AW handshakes this cycle may already send its first beat.
  assign bursts_avail = (w_cnt < aw_cnt) | aw_hs;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state: start on the strobe, finish on the final write response.
  always_comb begin
    state_d     = state_q;
    erase_start = 1'b0;
    erase_done  = 1'b0;
    case (state_q)
      IDLE: if (erase_ram) begin
        erase_start = 1'b1;
        state_d     = RUN;
      end
      RUN: if (b_hs && (b_cnt == NBURSTS - 32'd1)) begin
        erase_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst bookkeeping: issued, data-complete, responded and in-flight counts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_cnt        <= '0;
      w_cnt         <= '0;
      b_cnt         <= '0;
      outstanding_q <= '0;
      awaddr_q      <= BASE_ADDR;
      erase_error_q <= 1'b0;
    end else if (erase_start) begin
      aw_cnt        <= '0;
      w_cnt         <= '0;
      b_cnt         <= '0;
      outstanding_q <= '0;
      awaddr_q      <= BASE_ADDR;
      erase_error_q <= 1'b0;
    end else if (run) begin
      if (aw_hs) begin
        aw_cnt   <= aw_cnt + 32'd1;
        awaddr_q <= awaddr_q + BURST_BYTES;
      end
      if (burst_done) w_cnt <= w_cnt + 32'd1;
      if (b_hs) begin
        b_cnt <= b_cnt + 32'd1;
        if (m_axi.M_AXI_BRESP != AXI_RESP_OKAY) erase_error_q <= 1'b1;
      end
      case ({aw_hs, b_hs})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  erase_w_gen #(.BURST_BEATS(BURST_BEATS)) u_w_gen (
    .clk          (clk),
    .resetn       (resetn),
    .run          (run),
    .bursts_avail (bursts_avail),
    .wready       (m_axi.M_AXI_WREADY),
    .wvalid       (m_axi.M_AXI_WVALID),
    .wlast        (m_axi.M_AXI_WLAST),
    .burst_done   (burst_done)
  );

  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWLEN   = 8'(BURST_BEATS - 1);
  assign m_axi.M_AXI_AWSIZE  = axi_size(DATA_WBITS);
  assign m_axi.M_AXI_AWBURST = AXI_BURST_INCR;
  assign m_axi.M_AXI_AWVALID = awvalid;
  assign m_axi.M_AXI_WDATA   = {(DATA_WBITS / 32){FILL_PATTERN}};
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_BREADY  = run;

  assign erase_idle  = (state_q == IDLE);
  assign erase_error = erase_error_q;
  assign dbg_state   = state_q;

`ifdef BANK_ERASE_TIMER_EN
  logic [31:0] timer_q, timer_inc, cycles_q;

  assign timer_inc = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;

  // Count RUN cycles (saturating) and latch the total including the final cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_q  <= '0;
      cycles_q <= '0;
    end else begin
      if (erase_start) timer_q <= '0;
      else if (run)    timer_q <= timer_inc;
      if (erase_done)  cycles_q <= timer_inc;
    end
  end

  assign erase_cycles = cycles_q;
`else
  assign erase_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_bank_erase_ctrl.sv
// Self-checking bench for bank_erase_ctrl: a randomized AXI slave with a byte
// memory model, an expected-address scoreboard and end-of-erase checks.
module tb_bank_erase_ctrl;
  import bank_erase_pkg::*;

  localparam int          DATA_WBITS = 512;
  localparam int          ADDR_BITS  = 64;
  localparam logic [63:0] RAM_BYTES  = 64'd16384;
  localparam int          NB         = 64;      // 16384 / (4 beats * 64 bytes)
  localparam int          STRIDE     = 256;     // bytes per burst
  localparam int          BEATS      = 4;
  localparam int          MAX_OUT    = 4;
  localparam int          WORDS      = 4096;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         erase_ram = 1'b0;
  logic         erase_idle, erase_error;
  logic [31:0]  erase_cycles;
  erase_state_e dbg_state;

  always #5 clk = ~clk;

  bank_erase_ctrl_if #(.DATA_WBITS(DATA_WBITS), .ADDR_BITS(ADDR_BITS)) axi_if ();

  bank_erase_ctrl #(
    .DATA_WBITS(DATA_WBITS), .ADDR_BITS(ADDR_BITS), .BASE_ADDR(64'h0),
    .RAM_BYTES(RAM_BYTES), .BURST_BEATS(BEATS), .MAX_OUTSTANDING(MAX_OUT),
    .FILL_PATTERN(32'hFFFF_FFFF)
  ) dut (
    .clk(clk), .resetn(resetn), .erase_ram(erase_ram), .erase_idle(erase_idle),
    .erase_error(erase_error), .erase_cycles(erase_cycles), .dbg_state(dbg_state),
    .m_axi(axi_if)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] w_addr_q[$];
  logic [31:0] mem [WORDS];
  int aw_count, w_beat, w_bursts, b_count, b_pend, b_presented, run_cycles;
  int err_burst = -1;
  int aw_prob = 100, w_prob = 100, b_prob = 100;
  bit b_en = 1'b1, b_taken = 1'b0, idle_chk = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    w_addr_q.delete();
    aw_count = 0; w_beat = 0; w_bursts = 0; b_count = 0;
    b_pend = 0; b_presented = 0; run_cycles = 0;
    b_taken = 1'b0; idle_chk = 1'b0;
  endtask

  // ---------------- monitor: observe handshakes at negedge ----------------
  task automatic monitor_cycle();
    logic [63:0] a;
    int widx;
    if (idle_chk) begin
      check("idle_after_last_b", 64'(erase_idle), 64'd1);
      idle_chk = 1'b0;
    end
    if (!erase_idle) run_cycles++;
    if (axi_if.M_AXI_AWVALID)
      check("aw_below_max_outstanding", 64'((aw_count - b_count) < MAX_OUT), 64'd1);
    if (axi_if.M_AXI_AWVALID && axi_if.M_AXI_AWREADY) begin
      check("aw_len", 64'(axi_if.M_AXI_AWLEN), 64'd3);
      check("aw_size", 64'(axi_if.M_AXI_AWSIZE), 64'd6);
      check("aw_burst", 64'(axi_if.M_AXI_AWBURST), 64'd1);
      if (exp_q.size() == 0) check("aw_queue_nonempty", 64'(exp_q.size()), 64'd1);
      else                   check("aw_addr", axi_if.M_AXI_AWADDR, exp_q.pop_front());
      w_addr_q.push_back(axi_if.M_AXI_AWADDR);
      aw_count++;
    end
    if (axi_if.M_AXI_WVALID && axi_if.M_AXI_WREADY) begin
      check("w_after_aw", 64'(w_addr_q.size() != 0), 64'd1);
      check("w_last", 64'(axi_if.M_AXI_WLAST), 64'(w_beat == BEATS - 1));
      check("w_strb", 64'(axi_if.M_AXI_WSTRB), 64'hFFFF_FFFF_FFFF_FFFF);
      if (w_addr_q.size() != 0) begin
        a = w_addr_q[0] + 64'(w_beat * 64);
        check("w_addr_in_bank", 64'(a < RAM_BYTES), 64'd1);
        if (a < RAM_BYTES) begin
          widx = int'(a >> 2);
          for (int i = 0; i < 16; i++) mem[widx + i] = axi_if.M_AXI_WDATA[32*i +: 32];
        end
      end
      if (w_beat == BEATS - 1) begin
        w_beat = 0;
        w_bursts++;
        b_pend++;
        if (w_addr_q.size() != 0) void'(w_addr_q.pop_front());
      end else begin
        w_beat++;
      end
    end
    if (axi_if.M_AXI_BVALID && axi_if.M_AXI_BREADY) begin
      b_taken = 1'b1;
      b_count++;
      if (b_count == NB) begin
        check("idle_low_at_last_b", 64'(erase_idle), 64'd0);
        idle_chk = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (resetn) monitor_cycle();
  end

  // ---------------- driver: slave readies and B responses ----------------
  initial begin
    axi_if.M_AXI_AWREADY = 1'b0;
    axi_if.M_AXI_WREADY  = 1'b0;
    axi_if.M_AXI_BVALID  = 1'b0;
    axi_if.M_AXI_BRESP   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        axi_if.M_AXI_AWREADY = 1'b0;
        axi_if.M_AXI_WREADY  = 1'b0;
        axi_if.M_AXI_BVALID  = 1'b0;
      end else begin
        axi_if.M_AXI_AWREADY = ($urandom_range(0, 99) < aw_prob);
        axi_if.M_AXI_WREADY  = ($urandom_range(0, 99) < w_prob);
        if (!(axi_if.M_AXI_BVALID && !b_taken)) begin
          axi_if.M_AXI_BVALID = 1'b0;
          b_taken = 1'b0;
          if (b_en && b_pend > 0 && $urandom_range(0, 99) < b_prob) begin
            axi_if.M_AXI_BVALID = 1'b1;
            axi_if.M_AXI_BRESP  = (b_presented == err_burst) ? 2'b10 : 2'b00;
            b_presented++;
            b_pend--;
          end
        end
      end
    end
  end

  // ---------------- erase sequencing tasks ----------------
  task automatic start_erase();
    model_clear();
    for (int k = 0; k < NB; k++) exp_q.push_back(64'(k * STRIDE));
    foreach (mem[i]) mem[i] = 32'h0;
    @(posedge clk); #1 erase_ram = 1'b1;
    @(negedge clk);
    check("idle_in_strobe_cycle", 64'(erase_idle), 64'd1);
    @(posedge clk); #1 erase_ram = 1'b0;
    check("idle_low_after_strobe", 64'(erase_idle), 64'd0);
  endtask

  task automatic wait_for(input string what, input int target, input bit use_b);
    int n = 0;
    while (n < 3000 && ((use_b ? b_count : aw_count) < target)) begin
      @(negedge clk);
      n++;
    end
    check(what, 64'(n < 3000), 64'd1);
  endtask

  task automatic finish_erase(input logic exp_err);
    int n = 0;
    int bad = 0;
    while (n < 6000 && !(b_count >= NB && erase_idle)) begin
      @(negedge clk);
      n++;
    end
    check("erase_done_in_budget", 64'(n < 6000), 64'd1);
    repeat (2) @(negedge clk);
    check("aw_total", 64'(aw_count), 64'(NB));
    check("w_bursts_total", 64'(w_bursts), 64'(NB));
    check("b_total", 64'(b_count), 64'(NB));
    check("idle_end", 64'(erase_idle), 64'd1);
    check("erase_error", 64'(erase_error), 64'(exp_err));
`ifdef BANK_ERASE_TIMER_EN
    check("erase_cycles", 64'(erase_cycles), 64'(run_cycles));
`else
    check("erase_cycles_off", 64'(erase_cycles), 64'd0);
`endif
    foreach (mem[i]) if (mem[i] !== 32'hFFFF_FFFF) bad++;
    check("mem_bad_words", 64'(bad), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_idle", 64'(erase_idle), 64'd1);
    check("rst_error", 64'(erase_error), 64'd0);
    check("rst_cycles", 64'(erase_cycles), 64'd0);
    check("rst_awvalid", 64'(axi_if.M_AXI_AWVALID), 64'd0);
    check("rst_wvalid", 64'(axi_if.M_AXI_WVALID), 64'd0);
    check("rst_wlast", 64'(axi_if.M_AXI_WLAST), 64'd0);
    check("rst_bready", 64'(axi_if.M_AXI_BREADY), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: always-ready slave, immediate B; full W bandwidth expected.
    start_erase();
    finish_erase(1'b0);
    check("run_cycles_full_rate", 64'(run_cycles), 64'd257);

    // 2: B withheld -> AW issue stops at the outstanding limit.
    b_en = 1'b0;
    start_erase();
    repeat (30) @(negedge clk);
    check("aw_hold_count", 64'(aw_count), 64'(MAX_OUT));
    check("awvalid_hold", 64'(axi_if.M_AXI_AWVALID), 64'd0);
    b_en = 1'b1;
    finish_erase(1'b0);

    // 3: random backpressure on all three channels.
    for (int r = 0; r < 10; r++) begin
      aw_prob = int'($urandom_range(30, 100));
      w_prob  = int'($urandom_range(30, 100));
      b_prob  = int'($urandom_range(30, 100));
      start_erase();
      finish_erase(1'b0);
    end

    // 4: one SLVERR response, then a clean erase clears the flag.
    aw_prob = 80; w_prob = 90; b_prob = 70;
    err_burst = 17;
    start_erase();
    finish_erase(1'b1);
    err_burst = -1;
    start_erase();
    finish_erase(1'b0);

    // 5: re-strobe mid-erase is ignored; async reset aborts; fresh erase works.
    aw_prob = 100; w_prob = 100; b_prob = 60;
    start_erase();
    wait_for("reach_aw_10", 10, 1'b0);
    @(posedge clk); #1 erase_ram = 1'b1;
    @(posedge clk); #1 erase_ram = 1'b0;
    check("restrobe_still_busy", 64'(erase_idle), 64'd0);
    check("restrobe_state_run", 64'(dbg_state), 64'(RUN));
    wait_for("reach_b_30", 30, 1'b1);
    @(posedge clk); #3 resetn = 1'b0;
    #1;
    check("abort_idle", 64'(erase_idle), 64'd1);
    check("abort_awvalid", 64'(axi_if.M_AXI_AWVALID), 64'd0);
    check("abort_wvalid", 64'(axi_if.M_AXI_WVALID), 64'd0);
    check("abort_bready", 64'(axi_if.M_AXI_BREADY), 64'd0);
    check("abort_error", 64'(erase_error), 64'd0);
    check("abort_cycles", 64'(erase_cycles), 64'd0);
    axi_if.M_AXI_BVALID  = 1'b0;
    axi_if.M_AXI_AWREADY = 1'b0;
    axi_if.M_AXI_WREADY  = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    start_erase();
    finish_erase(1'b0);

    // 6: always-ready again; duration reporting checked against observed RUN cycles.
    b_prob = 100;
    start_erase();
    finish_erase(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
